fm_wm_transform: RTL

FM_WM_TRANSFORM -- requirements
Module: fm_wm_transform

---
 rtl/gcn_pkg.sv | 23 ++
 rtl/fm_wm_dot_product.sv | 27 ++
 rtl/fm_wm_transform.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/gcn_pkg.sv
// rtl/gcn_pkg.sv - shared parameter defaults and sequencer state encoding for the FM*WM transform
package gcn_pkg;

    localparam int DEF_FEATURE_COLS   = 96;
    localparam int DEF_FEATURE_ROWS   = 6;
    localparam int DEF_WEIGHT_ROWS    = 96;
    localparam int DEF_WEIGHT_COLS    = 3;
    localparam int DEF_FEATURE_WIDTH  = 5;
    localparam int DEF_WEIGHT_WIDTH   = 5;
    localparam int DEF_DOT_PROD_WIDTH = 16;
    localparam int DEF_ADDRESS_WIDTH  = 13;
    localparam int DEF_COO_BW         = 3;

    typedef enum logic [2:0] {
        IDLE,
        W_ADDR,
        W_CAP,
        F_ADDR,
        F_MAC,
        DONE
    } state_t;

endpackage

// File: rtl/fm_wm_dot_product.sv
// rtl/fm_wm_dot_product.sv - combinational unsigned dot product of one feature row and one weight column
module fm_wm_dot_product #(
    parameter int COLS  = 96,
    parameter int FW    = 5,
    parameter int WW    = 5,
    parameter int OUT_W = 16
) (
    input  logic [COLS-1:0][FW-1:0] feature_row,
    input  logic [COLS-1:0][WW-1:0] weight_col,
    output logic [OUT_W-1:0]        dot
);

    localparam int PROD_W = FW + WW;

    logic [PROD_W-1:0] prod;

    // Products are exact; accumulating in OUT_W bits keeps the same low bits as a full-width sum.
    always_comb begin
        dot  = '0;
        prod = '0;
        for (int i = 0; i < COLS; i++) begin
            prod = PROD_W'(feature_row[i]) * PROD_W'(weight_col[i]);
            dot  = dot + OUT_W'(prod);
        end
    end

endmodule

// File: rtl/fm_wm_transform.sv
// rtl/fm_wm_transform.sv - sequences weight/feature reads and stores the FM*WM product matrix
module fm_wm_transform
    import gcn_pkg::*;
#(
    parameter int FEATURE_COLS   = DEF_FEATURE_COLS,
    parameter int FEATURE_ROWS   = DEF_FEATURE_ROWS,
    parameter int WEIGHT_ROWS    = DEF_WEIGHT_ROWS,
    parameter int WEIGHT_COLS    = DEF_WEIGHT_COLS,
    parameter int FEATURE_WIDTH  = DEF_FEATURE_WIDTH,
    parameter int WEIGHT_WIDTH   = DEF_WEIGHT_WIDTH,
    parameter int DOT_PROD_WIDTH = DEF_DOT_PROD_WIDTH,
    parameter int ADDRESS_WIDTH  = DEF_ADDRESS_WIDTH,
    parameter int COO_BW         = DEF_COO_BW
) (
    input  logic                                         clk,
    input  logic                                         reset,
    input  logic                                         start,
    output logic [ADDRESS_WIDTH-1:0]                     weight_read_addr,
    output logic                                         weight_read_en,
    input  logic [WEIGHT_ROWS-1:0][WEIGHT_WIDTH-1:0]     weight_col_in,
    output logic [ADDRESS_WIDTH-1:0]                     feature_read_addr,
    output logic                                         feature_read_en,
    input  logic [FEATURE_COLS-1:0][FEATURE_WIDTH-1:0]   feature_row_in,
    input  logic [COO_BW-1:0]                            read_row_fw,
    output logic [WEIGHT_COLS-1:0][DOT_PROD_WIDTH-1:0]   fm_wm_row_data,
    output logic                                         done
);

    localparam int R_W = $clog2(FEATURE_ROWS);
    localparam int C_W = $clog2(WEIGHT_COLS);

    state_t                                                     state_q, state_d;
    logic [C_W-1:0]                                             c_q, c_d;
    logic [R_W-1:0]                                             r_q, r_d;
    logic [WEIGHT_ROWS-1:0][WEIGHT_WIDTH-1:0]                   wreg_q, wreg_d;
    logic [FEATURE_ROWS-1:0][WEIGHT_COLS-1:0][DOT_PROD_WIDTH-1:0] mem_q, mem_d;
    logic                                                       done_q, done_d;
    logic                                                       wen_q, wen_d;
    logic                                                       fen_q, fen_d;
    logic [ADDRESS_WIDTH-1:0]                                   waddr_q, waddr_d;
    logic [ADDRESS_WIDTH-1:0]                                   faddr_q, faddr_d;
    logic [DOT_PROD_WIDTH-1:0]                                  dot;

    fm_wm_dot_product #(
        .COLS  (FEATURE_COLS),
        .FW    (FEATURE_WIDTH),
        .WW    (WEIGHT_WIDTH),
        .OUT_W (DOT_PROD_WIDTH)
    ) u_dot (
        .feature_row (feature_row_in),
        .weight_col  (wreg_q),
        .dot         (dot)
    );

    always_comb begin
        state_d = state_q;
        c_d     = c_q;
        r_d     = r_q;
        wreg_d  = wreg_q;
        mem_d   = mem_q;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d = W_ADDR;
                    c_d     = '0;
                    r_d     = '0;
                end
            end
            W_ADDR: state_d = W_CAP;
            W_CAP: begin
                wreg_d  = weight_col_in;
                state_d = F_ADDR;
            end
            F_ADDR: state_d = F_MAC;
            F_MAC: begin
                mem_d[r_q][c_q] = dot;
                if (r_q < R_W'(FEATURE_ROWS - 1)) begin
                    r_d     = r_q + 1'b1;
                    state_d = F_ADDR;
                end else begin
                    r_d = '0;
                    if (c_q < C_W'(WEIGHT_COLS - 1)) begin
                        c_d     = c_q + 1'b1;
                        state_d = W_ADDR;
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // Strobes and addresses are registered from the next state so they align with W_ADDR/F_ADDR.
        wen_d   = (state_d == W_ADDR);
        fen_d   = (state_d == F_ADDR);
        waddr_d = wen_d ? ADDRESS_WIDTH'(c_d) : '0;
        faddr_d = fen_d ? ADDRESS_WIDTH'(r_d) : '0;
        done_d  = (state_q == DONE) && !start;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            c_q     <= '0;
            r_q     <= '0;
            wreg_q  <= '0;
            mem_q   <= '0;
            done_q  <= 1'b0;
            wen_q   <= 1'b0;
            fen_q   <= 1'b0;
            waddr_q <= '0;
            faddr_q <= '0;
        end else begin
            state_q <= state_d;
            c_q     <= c_d;
            r_q     <= r_d;
            wreg_q  <= wreg_d;
            mem_q   <= mem_d;
            done_q  <= done_d;
            wen_q   <= wen_d;
            fen_q   <= fen_d;
            waddr_q <= waddr_d;
            faddr_q <= faddr_d;
        end
    end

    always_comb begin
        fm_wm_row_data = '0;
        for (int i = 0; i < FEATURE_ROWS; i++) begin
            if (read_row_fw == COO_BW'(i)) fm_wm_row_data = mem_q[i];
        end
    end

    assign weight_read_en    = wen_q;
    assign weight_read_addr  = waddr_q;
    assign feature_read_en   = fen_q;
    assign feature_read_addr = faddr_q;
    assign done              = done_q;

endmodule
